// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register access controller.
// Runs a two-write PHY init sequence, then serves user register reads and writes.
module ulpi_reg_ctrl #(
  parameter logic [7:0] FUNC_CTRL_INIT = 8'h48,
  parameter logic [7:0] OTG_CTRL_INIT  = 8'h00,
  parameter int         TIMEOUT        = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  input  logic       req_valid_i,
  input  logic       req_write_i,
  input  logic [5:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       req_ready_o,
  output logic       resp_valid_o,
  output logic [7:0] resp_rdata_o,
  output logic       resp_err_o,
  output logic       init_done_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WDATA, STOP, RTURN, RDATA
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          init_ptr_q;
  logic          init_done_q;
  logic          op_valid_q;
  logic          op_write_q;
  logic [5:0]    op_addr_q;
  logic [7:0]    op_wdata_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [7:0]    resp_rdata_q;

  logic          init_act;
  logic          cur_write;
  logic [5:0]    cur_addr;
  logic [7:0]    cur_wdata;
  logic          accept;
  logic          tmo;
  logic          rd_done;
  logic          tmo_hit;
  logic          fin;

  // Until init completes, the in-flight op is the init write at init_ptr_q.
  assign init_act  = !init_done_q;
  assign cur_write = init_act | op_write_q;
  assign cur_addr  = init_act ? (init_ptr_q ? 6'h0A : 6'h04) : op_addr_q;
  assign cur_wdata = init_act ? (init_ptr_q ? OTG_CTRL_INIT : FUNC_CTRL_INIT)
                              : op_wdata_q;

  assign req_ready_o = (state_q == IDLE) & init_done_q &
                       !op_valid_q & !ulpi_dir_i;
  assign accept      = req_valid_i & req_ready_o;
  assign tmo         = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rd_done = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((init_act | op_valid_q | accept) && !ulpi_dir_i)
          state_d = CMD;
      end
      CMD: begin
        if (ulpi_dir_i)      state_d = IDLE;
        else if (ulpi_nxt_i) state_d = cur_write ? WDATA : RTURN;
      end
      WDATA: begin
        if (ulpi_dir_i)      state_d = IDLE;
        else if (ulpi_nxt_i) state_d = STOP;
      end
      STOP:  state_d = IDLE;
      RTURN: begin
        if (ulpi_dir_i) state_d = RDATA;
      end
      RDATA: begin
        // Any other bus condition is a preemption; the op is retried.
        state_d = IDLE;
        rd_done = ulpi_dir_i & !ulpi_nxt_i;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d == state_q && tmo) begin
      state_d = IDLE;
      tmo_hit = 1'b1;
    end
  end

  assign fin = (state_q == STOP) | rd_done | tmo_hit;

  always_comb begin
    ulpi_data_o = 8'h00;
    unique case (state_q)
      CMD:     ulpi_data_o = {1'b1, ~cur_write, cur_addr};
      WDATA:   ulpi_data_o = cur_wdata;
      default: ulpi_data_o = 8'h00;
    endcase
  end

  assign ulpi_stp_o   = (state_q == STOP);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign init_done_o  = init_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      init_ptr_q   <= 1'b0;
      init_done_q  <= 1'b0;
      op_valid_q   <= 1'b0;
      op_write_q   <= 1'b0;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      if (state_d != state_q || state_d == IDLE) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        op_valid_q <= 1'b1;
        op_write_q <= req_write_i;
        op_addr_q  <= req_addr_i;
        op_wdata_q <= req_wdata_i;
      end
      if (fin) begin
        if (init_act) begin
          init_ptr_q <= 1'b1;
          if (init_ptr_q) init_done_q <= 1'b1;
        end else begin
          op_valid_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= tmo_hit;
          resp_rdata_q <= rd_done ? ulpi_data_i : 8'h00;
        end
      end
    end
  end

endmodule

// File: doc/ulpi_reg_ctrl.md
ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

Interface
REQ-001 SHALL have parameter FUNC_CTRL_INIT, default 8'h48, value written to PHY Function Control (addr 6'h04) after reset.
REQ-002 SHALL have parameter OTG_CTRL_INIT, default 8'h00, value written to PHY OTG Control (addr 6'h0A) after reset.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles in any non-IDLE state.
REQ-004 Ports:
- clk_i  in  1  ULPI 60MHz clock; the block's one clock.
- rst_i  in  1  reset, asynchronous, active-high.
- ulpi_data_i  in  8  PHY-to-link data.
- ulpi_data_o  out  8  link-to-PHY data.
- ulpi_dir_i  in  1  PHY owns bus when 1.
- ulpi_nxt_i  in  1  PHY throttle.
- ulpi_stp_o  out  1  stop.
- req_valid_i  in  1  user register request.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  6  register address.
- req_wdata_i  in  8  write data.
- req_ready_o  out  1  request accepted when valid&ready.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  8  read data; 0 for writes.
- resp_err_o  out  1  completion was a timeout; valid with resp_valid_o.
- init_done_o  out  1  both init writes complete.

Function
REQ-005 FSM states SHALL be IDLE, CMD, WDATA, STOP, RTURN, RDATA.
REQ-006 Init sequencer SHALL have priority: init write FUNC_CTRL_INIT, then OTG_CTRL_INIT, before any user request; init completions SHALL NOT pulse resp_valid_o.
REQ-007 req_ready_o SHALL be 1 only in IDLE with init_done_o=1, no retry pending, ulpi_dir_i=0; accepted op latched (addr, wdata, write) and held until completion.
REQ-008 IDLE: ulpi_data_o=0, ulpi_stp_o=0; with pending op and ulpi_dir_i=0, next state CMD.
REQ-009 CMD: ulpi_data_o={2'b10,addr} for write, {2'b11,addr} for read; nxt=1 & dir=0 -> WDATA (write) or RTURN (read).
REQ-010 WDATA: ulpi_data_o=wdata; nxt=1 -> STOP.
REQ-011 STOP: ulpi_stp_o=1, ulpi_data_o=0 for exactly one cycle; write complete; -> IDLE.
REQ-012 RTURN: ulpi_data_o=0; dir=1 (turnaround cycle) -> RDATA.
REQ-013 RDATA: dir=1 & nxt=0 -> capture ulpi_data_i into resp_rdata_o, complete, -> IDLE.
REQ-014 dir=1 in CMD or WDATA, or dir=1 & nxt=1 in RDATA (RX CMD preemption), SHALL abort to IDLE with op retained and reissued once dir=0; no completion, no error.
REQ-015 dir=0 in RDATA SHALL abort and retry as REQ-014.
REQ-016 Cycle counter SHALL clear on every state change; reaching TIMEOUT in a non-IDLE state -> IDLE, op dropped, resp_valid_o=1, resp_err_o=1 (user op) or init step skipped (init op).
REQ-017 Write latency: minimum 3 cycles CMD->STOP exit, completion pulse the cycle after STOP.
REQ-018 init_done_o SHALL rise the cycle after the second init STOP and stay 1 until reset.
REQ-019 ulpi_stp_o SHALL never assert outside STOP.

Reset
REQ-020 rst_i=1 SHALL immediately force IDLE, ulpi_data_o=0, ulpi_stp_o=0, req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, init_done_o=0, init pointer 0, counter 0, retry cleared.
REQ-021 Reset mid-transfer SHALL discard the op; init sequence restarts after release.

Verification
REQ-022 Release reset, nxt=1 whenever dir=0 -> data_o 8'h84,8'h48,stp; 8'h8A,8'h00,stp; init_done_o=1.
REQ-023 After init, write addr 6'h16 data 8'hA5, PHY nxt on 2nd CMD cycle -> 8'h96 held 2 cycles, 8'hA5, stp, resp_valid_o=1 rdata 0 err 0.
REQ-024 Read addr 6'h04, PHY nxt, dir 1 turnaround, data 8'h48 with nxt=0 -> resp_rdata_o=8'h48, one pulse.
REQ-025 dir=1 for 3 cycles during WDATA -> stp never asserted, CMD reissued after dir=0, single completion.
REQ-026 nxt held 0 in CMD -> completion at TIMEOUT with resp_err_o=1; next request accepted.
REQ-027 rst_i pulsed in WDATA -> outputs zero same cycle, init writes repeat.
